// File: rtl/dpr_pkg.sv
// dpr_pkg: shared FSM states, read-during-write constants and byte-merge helper for dual_port_ram_be
package dpr_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int MAX_W   = 1024;
  localparam int MAX_BE  = MAX_W / 8;
  // Callers zero-extend to MAX_W and truncate the result back to their own width.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BE; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dpr_rd_pipe.sv
// dpr_rd_pipe: read-data/valid pipeline of RD_LAT stages (1 or 2); data holds its last value
// ports: clk, rst_n (async active-low), v_i/d_i request result, v_o/d_o delayed strobe and data
module dpr_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_i,
  input  logic [DATA_W-1:0] d_i,
  output logic              v_o,
  output logic [DATA_W-1:0] d_o
);
  logic              v1_q, v2_q;
  logic [DATA_W-1:0] d1_q, d2_q;
  // Stage 2 copies stage 1 unconditionally: stage 1 already holds, so stage 2 holds too.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v_i;
      if (v_i) d1_q <= d_i;
      v2_q <= v1_q;
      d2_q <= d1_q;
    end
  assign v_o = (RD_LAT == 2) ? v2_q : v1_q;
  assign d_o = (RD_LAT == 2) ? d2_q : d1_q;
endmodule

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port RAM with byte enables, 1/2-cycle reads, collision strobe and zero-fill sweep
// ports: clk, rst_n (async active-low); per port en/we/be/addr/data in, q/q_valid out;
//        collision (same-address byte overlap of two writes), init_busy (zero-fill sweep running)
module dual_port_ram_be
  import dpr_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 6,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   data_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_b,
  output logic [DATA_W-1:0]   q_a,
  output logic                q_valid_a,
  output logic [DATA_W-1:0]   q_b,
  output logic                q_valid_b,
  output logic                collision,
  output logic                init_busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  state_e            state_q;
  logic [ADDR_W-1:0] clr_q;
  logic              init_busy_q, collision_q, collision_d;
  logic              ready, wr_a, wr_b, same, rv_a, rv_b;
  logic [DATA_W-1:0] old_a, old_b, mg_a, mg_b, word_a, rd_a, rd_b;
  assign ready  = state_q == ST_READY;
  assign wr_a   = ready & en_a & we_a;
  assign wr_b   = ready & en_b & we_b;
  assign same   = wr_a & wr_b & (addr_a == addr_b);
  assign old_a  = mem_q[addr_a];
  assign old_b  = mem_q[addr_b];
  assign mg_a   = DATA_W'(byte_merge(MAX_W'(old_a), MAX_W'(data_a), MAX_BE'(be_a)));
  assign mg_b   = DATA_W'(byte_merge(MAX_W'(old_b), MAX_W'(data_b), MAX_BE'(be_b)));
  // On a same-address write A is merged on top of B's result, so A wins only its own bytes.
  assign word_a = DATA_W'(byte_merge(MAX_W'(same ? mg_b : old_a), MAX_W'(data_a), MAX_BE'(be_a)));
  assign collision_d = same & |(be_a & be_b);
  // Write-first shows the port's own merged word; reads see pre-edge contents on both ports.
  assign rv_a = ready & en_a & (~we_a | (RDW_MODE == RDW_NEW));
  assign rv_b = ready & en_b & (~we_b | (RDW_MODE == RDW_NEW));
  assign rd_a = we_a ? mg_a : old_a;
  assign rd_b = we_b ? mg_b : old_b;
  always_ff @(posedge clk)
    if (state_q == ST_CLEAR) mem_q[clr_q] <= '0;
    else begin
      if (wr_b) mem_q[addr_b] <= mg_b;
      if (wr_a) mem_q[addr_a] <= word_a;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_q       <= '0;
      init_busy_q <= CLEAR_ON_RESET != 0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
      if (state_q == ST_CLEAR) begin
        clr_q <= clr_q + 1'b1;
        if (&clr_q) begin
          state_q     <= ST_READY;
          init_busy_q <= 1'b0;
        end
      end
    end
  dpr_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk(clk), .rst_n(rst_n), .v_i(rv_a), .d_i(rd_a), .v_o(q_valid_a), .d_o(q_a)
  );
  dpr_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk(clk), .rst_n(rst_n), .v_i(rv_b), .d_i(rd_b), .v_o(q_valid_b), .d_o(q_b)
  );
  assign collision = collision_q;
  assign init_busy = init_busy_q;
endmodule
